freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Measures the frequency of an external square wave (sig_in) against the 12 MHz system clock.
//  Counts rising edges inside a fixed gate window and reports the count, which equals Hz for a 1 s gate.
//  Sits downstream of the clock divider; its 2 MHz / 1000 Hz outputs are valid loopback sources.
//  Result feeds the display/segment logic.
// PARAMETERS
//  GATE_CYCLES  12_000_000  gate window length in clk12Mhz cycles (1 s); legal range 2..2^32-1
//  CNT_W        24          width of edge counter and freq_out
// PORTS
//  clk12Mhz   in   1      system clock, 12 MHz, sole clock domain
//  rst        in   1      asynchronous, active-high reset
//  sig_in     in   1      asynchronous measured signal; high and low phases each >= 2 clk periods
//  start      in   1      one-cycle request to begin a measurement
//  busy       out  1      high while a gate window is open
//  freq_out   out  CNT_W  last completed edge count; held until the next result
//  valid      out  1      one-cycle pulse when freq_out updates
//  ovf        out  1      last result saturated; updates together with valid
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE, counters 0, sync flops 0. Reset mid-gate discards the partial count.
//  - Input path: 2-flop synchronizer, then a registered rising-edge detect.
//    A sig_in rise is counted 3 clk later (edge_pulse).
//  - FSM states: IDLE, GATE, LATCH.
//    IDLE : busy=0; start=1 -> GATE; gate_cnt<=0, edge_cnt<=0, ovf_acc<=0.
//    GATE : busy=1; gate_cnt increments each cycle; edge_pulse increments edge_cnt;
//           when gate_cnt==GATE_CYCLES-1 -> LATCH. start is ignored.
//    LATCH: busy=0; freq_out<=edge_cnt, ovf<=ovf_acc, valid=1 for this cycle only; -> IDLE.
//  - Window: exactly GATE_CYCLES cycles. An edge_pulse on the last GATE cycle is counted.
//    An edge_pulse in LATCH or IDLE is not counted.
//  - Saturation: edge_cnt stops at 2^CNT_W-1 and sets ovf_acc; it never wraps.
//  - start in LATCH is ignored. start in IDLE on the cycle after LATCH is accepted.
//  - gate_cnt is 32 bits and is compared for equality only.
//  - freq_out and ovf change only in LATCH. Between results they hold their values.
// CONFIGURATION
//  FREQ_AUTO_RUN_EN defined:
//    LATCH -> GATE directly, with counters cleared. Measurements run back-to-back from reset release.
//    The start port is present but ignored. valid pulses every GATE_CYCLES+1 cycles.
//    busy=1 except during LATCH.
//  FREQ_AUTO_RUN_EN undefined:
//    single-shot operation on start, as described above.
// STRUCTURE
//  freq_meter_pkg: FSM state enum {IDLE, GATE, LATCH}, GATE_W=32 localparam, default CNT_W.
//  Sub-module edge_sync (clk, rst, async_in -> rise_pulse):
//    2-flop synchronizer plus edge detect; reusable for the buttons.
//  Top level: FSM, gate counter, saturating edge counter, output registers.
// TESTING (GATE_CYCLES=1000 unless noted)
//  1. Reset asserted mid-GATE with 40 edges counted -> busy/valid/freq_out/ovf = 0 immediately.
//     No valid pulse follows until a new start.
//  2. start pulse, sig_in = 1 MHz (period 12 clk) -> valid exactly 1001 cycles after start.
//     freq_out in 83..84, ovf=0.
//  3. start, sig_in held low -> freq_out=0, valid=1 once, busy low afterwards.
//  4. CNT_W=4, sig_in at 2 MHz (loopback from the divider) -> freq_out=15, ovf=1.
//  5. start pulsed repeatedly during GATE and during LATCH -> single valid.
//     Window length is unchanged (1000 cycles).
//  6. FREQ_AUTO_RUN_EN, sig_in=500 kHz -> valid every 1001 cycles.
//     freq_out stays within 41..42 across 5 windows.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM states and counter widths.
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_e;

  localparam int GATE_W        = 32;
  localparam int DEFAULT_CNT_W = 24;
endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Also intended for the push-button inputs.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);
  logic sync1_q, sync2_q, prev_q, rise_q;

  // A rise on async_in appears on rise_pulse three clocks later, one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_pulse = rise_q;
endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clocks and reports the total.
// Define FREQ_AUTO_RUN_EN for continuous back-to-back measurements (start is then ignored).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 12_000_000,
  parameter int          CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk12Mhz,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf
);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic edge_pulse;
  logic go;

  state_e            state_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d, freq_q;
  logic              ovf_acc_q, ovf_acc_d;
  logic              busy_q, valid_q, ovf_q;
  logic              gate_last;

  edge_sync u_edge_sync (
    .clk       (clk12Mhz),
    .rst       (rst),
    .async_in  (sig_in),
    .rise_pulse(edge_pulse)
  );

`ifdef FREQ_AUTO_RUN_EN
  logic unused_start;
  assign unused_start = start;
  assign go           = 1'b1;
`else
  assign go           = start;
`endif

  assign gate_last = (gate_cnt_q == GATE_LAST);

  // Saturating count: an edge arriving at full scale is dropped and flagged instead of wrapping.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_acc_d  = ovf_acc_q;
    if (edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) ovf_acc_d = 1'b1;
      else                       edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk12Mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_acc_q  <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q    <= GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        GATE: begin
          gate_cnt_q <= gate_cnt_q + 1'b1;
          edge_cnt_q <= edge_cnt_d;
          ovf_acc_q  <= ovf_acc_d;
          // Results load from the _d values so a pulse on the final gate cycle is included.
          if (gate_last) begin
            state_q <= LATCH;
            freq_q  <= edge_cnt_d;
            ovf_q   <= ovf_acc_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        LATCH: begin
`ifdef FREQ_AUTO_RUN_EN
          state_q    <= GATE;
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          ovf_acc_q  <= 1'b0;
          busy_q     <= 1'b1;
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign freq_out = freq_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table vectors, random waveforms and reset/back-to-back sequences.
// Two instances share the stimulus: a 24-bit counter and a 4-bit counter that saturates.
module tb_freq_meter;
  localparam int GC = 1000;

  logic        clk = 1'b0;
  logic        rst, sig_in, start;
  logic        busyA, validA, ovfA;
  logic [23:0] freqA;
  logic        busyB, validB, ovfB;
  logic [3:0]  freqB;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(24)) dutA (
    .clk12Mhz(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busyA), .freq_out(freqA), .valid(validA), .ovf(ovfA)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dutB (
    .clk12Mhz(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busyB), .freq_out(freqB), .valid(validB), .ovf(ovfB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    per;
    int    high;
    int    ph;
    bit    on;
    bit    spam;
    int    expLo;
    int    expHi;
    string name;
  } vec_t;

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;
  bit hist [0:32767];
  int wavePer   = 1;
  int waveHigh  = 0;
  int wavePh    = 0;
  bit waveOn    = 1'b0;
  int validCnt  = 0;
  int lastValid = -1;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    vecCount++;
    if (actual != required) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
    vecCount++;
    if (actual < lo || actual > hi) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs are sampled at the same point.
  task automatic applyStimulus(input bit st);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 32767) begin
      $display("[TB] FAIL cycle_budget: got %0d, required <= 32767", cyc);
      $fatal(1, "[TB] cycle budget exceeded");
    end
    sig_in    = waveOn && (((cyc + wavePh) % wavePer) < waveHigh);
    hist[cyc] = sig_in;
    start     = st;
    if (validA) begin
      validCnt++;
      lastValid = cyc;
    end
  endtask

  // A rise of sig_in first seen in cycle r is counted if r+3 falls inside the GATE cycles [g, g+GC-1].
  function automatic int modelCount(input int g);
    int n = 0;
    for (int r = g - 3; r <= g + GC - 4; r++)
      if (r >= 1 && hist[r] && !hist[r-1]) n++;
    return n;
  endfunction

  task automatic checkResult(input string name, input int n, input int lo, input int hi);
    checkOutput({name, ".freqA"}, freqA, n);
    checkRange ({name, ".range"}, freqA, lo, hi);
    checkOutput({name, ".ovfA"},  ovfA,  0);
    checkOutput({name, ".freqB"}, freqB, (n > 15) ? 15 : n);
    checkOutput({name, ".ovfB"},  ovfB,  (n > 15) ? 1 : 0);
  endtask

  task automatic measure(input vec_t v, input bit settle, input bit watchTail);
    int s, n;
    if (settle) begin
      waveOn = 1'b0;
      repeat (6) applyStimulus(1'b0);
    end
    wavePer  = v.per;
    waveHigh = v.high;
    wavePh   = v.ph;
    waveOn   = v.on;
    applyStimulus(1'b1);
    s         = cyc;
    validCnt  = 0;
    lastValid = -1;
    for (int k = 1; k <= GC; k++) begin
      applyStimulus(v.spam && (k % 97 == 0));
      if (k == GC / 2) checkOutput({v.name, ".busy_mid"}, busyA, 1);
    end
    applyStimulus(v.spam);
    checkOutput({v.name, ".valid_at"}, lastValid, s + GC + 1);
    n = modelCount(s + 1);
    checkResult(v.name, n, v.expLo, v.expHi);
    if (watchTail) begin
      repeat (100) applyStimulus(1'b0);
      checkOutput({v.name, ".valid_cnt"}, validCnt, 1);
      checkOutput({v.name, ".busy_after"}, busyA, 0);
    end
  endtask

  vec_t vecs [6];

  initial begin
    vec_t rv;
    rst    = 1'b1;
    sig_in = 1'b0;
    start  = 1'b0;
    repeat (3) applyStimulus(1'b0);
    checkOutput("reset.busy",  busyA,  0);
    checkOutput("reset.valid", validA, 0);
    checkOutput("reset.freq",  freqA,  0);
    checkOutput("reset.ovf",   ovfA,   0);
    checkOutput("reset.freqB", freqB,  0);
    rst = 1'b0;

`ifdef FREQ_AUTO_RUN_EN
    begin
      int nValid = 0;
      int prevV  = -1;
      wavePer = 24; waveHigh = 12; wavePh = 3; waveOn = 1'b1;
      for (int k = 0; k < 5 * (GC + 1) + 50 && nValid < 5; k++) begin
        applyStimulus(1'b0);
        if (k == 500) checkOutput("auto.busy", busyA, 1);
        if (validA) begin
          if (prevV >= 0) checkOutput("auto.spacing", cyc - prevV, GC + 1);
          checkResult("auto", modelCount(cyc - GC), 41, 42);
          prevV = cyc;
          nValid++;
        end
      end
      checkOutput("auto.windows", nValid, 5);
    end
`else
    vecs[0] = '{12, 6, 0, 1'b1, 1'b0, 83, 84, "1MHz"};
    vecs[1] = '{12, 6, 5, 1'b1, 1'b1, 83, 84, "1MHz_spam"};
    vecs[2] = '{24, 12, 7, 1'b1, 1'b0, 41, 42, "500kHz"};
    vecs[3] = '{6, 3, 2, 1'b1, 1'b0, 166, 167, "2MHz"};
    vecs[4] = '{4, 2, 1, 1'b1, 1'b1, 250, 250, "3MHz_spam"};
    vecs[5] = '{1, 0, 0, 1'b0, 1'b0, 0, 0, "low"};
    for (int i = 0; i < 6; i++) measure(vecs[i], 1'b1, 1'b1);

    // Start on the IDLE cycle directly after LATCH must be accepted.
    measure('{24, 12, 0, 1'b1, 1'b0, 41, 42, "b2b_first"}, 1'b1, 1'b0);
    measure('{24, 12, 0, 1'b1, 1'b0, 41, 42, "b2b_second"}, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rv.per   = $urandom_range(40, 4);
      rv.high  = $urandom_range(rv.per - 2, 2);
      rv.ph    = $urandom_range(rv.per - 1, 0);
      rv.on    = 1'b1;
      rv.spam  = 1'($urandom_range(1, 0));
      rv.expLo = GC / rv.per;
      rv.expHi = (GC + rv.per - 1) / rv.per;
      rv.name  = $sformatf("rand%0d_p%0d", i, rv.per);
      measure(rv, 1'b1, 1'b1);
    end

    // Reset in the middle of a gate: outputs clear at once and no result follows.
    waveOn = 1'b0;
    repeat (6) applyStimulus(1'b0);
    wavePer = 12; waveHigh = 6; wavePh = 0; waveOn = 1'b1;
    applyStimulus(1'b1);
    repeat (480) applyStimulus(1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset.busy",  busyA,  0);
    checkOutput("midreset.valid", validA, 0);
    checkOutput("midreset.freq",  freqA,  0);
    checkOutput("midreset.ovf",   ovfA,   0);
    checkOutput("midreset.ovfB",  ovfB,   0);
    waveOn = 1'b0;
    repeat (3) applyStimulus(1'b0);
    rst      = 1'b0;
    validCnt = 0;
    repeat (1100) applyStimulus(1'b0);
    checkOutput("midreset.no_valid", validCnt, 0);
    checkOutput("midreset.busy_after", busyA, 0);
    checkOutput("midreset.freq_after", freqA, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
